// File: rtl/ext_acc_slave.sv
// EXT bus slave: 16-word register file in front of an
// iterative 32x32->64 unsigned multiply-accumulate engine.
module ext_acc_slave #(
    parameter int AWIDTH     = 16,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EXT_HSEL,
    input  logic [AWIDTH-1:0] EXT_HADDR,
    input  logic              EXT_HWRITE,
    input  logic [3:0]        EXT_HSIZE,
    input  logic [31:0]       EXT_HWDATA,
    output logic [31:0]       EXT_HRDATA,
    output logic              EXT_HREADYOUT,
    output logic              busy
);

    localparam int CW = $clog2(MUL_CYCLES);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic          dv;
    logic          wr_ff;
    logic [3:0]    addr_ff;
    logic [3:0]    be_ff;
    logic [3:0]    be;
    logic [31:0]   opa, opb, res_lo, res_hi;
    logic          acc, done, run_acc;
    logic [63:0]   prod, mcand, next_prod, final_res;
    logic [31:0]   mplier;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata;
    logic          sample, stall, we, start, last, idle;
    logic          unused_bits;

    assign unused_bits = ^{EXT_HADDR[AWIDTH-1:6], EXT_HSIZE[3]};

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0]  lanes);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (lanes[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    always_comb begin
        be = 4'b0000;
        case (EXT_HSIZE[2:0])
            3'b000: be = 4'b0001 << EXT_HADDR[1:0];
            3'b001: begin
                if (EXT_HADDR[1:0] == 2'b00)      be = 4'b0011;
                else if (EXT_HADDR[1:0] == 2'b10) be = 4'b1100;
            end
            3'b010: if (EXT_HADDR[1:0] == 2'b00) be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign idle   = (state == IDLE);
    assign busy   = (state == RUN);
    // Result reads must wait for the engine so they never see a stale value
    assign stall  = dv && !wr_ff && busy &&
                    (addr_ff == 4'd4 || addr_ff == 4'd5);
    assign EXT_HREADYOUT = !stall;
    assign sample = EXT_HSEL && EXT_HREADYOUT;
    assign we     = dv && wr_ff && (be_ff != 4'b0000);
    assign start  = we && idle && (addr_ff == 4'd0) &&
                    be_ff[0] && EXT_HWDATA[0];
    assign last   = busy && (cnt == CW'(MUL_CYCLES - 1));

    assign next_prod = prod + (mplier[0] ? mcand : 64'd0);
    assign final_res = run_acc ? ({res_hi, res_lo} + next_prod)
                               : next_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv      <= 1'b0;
            wr_ff   <= 1'b0;
            addr_ff <= 4'd0;
            be_ff   <= 4'd0;
        end else if (EXT_HREADYOUT) begin
            dv <= sample;
            if (sample) begin
                wr_ff   <= EXT_HWRITE;
                addr_ff <= EXT_HADDR[5:2];
                be_ff   <= be;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            res_lo <= '0;
            res_hi <= '0;
            done   <= 1'b0;
        end else begin
            if (we) begin
                case (addr_ff)
                    4'd0: if (be_ff[0]) acc <= EXT_HWDATA[1];
                    4'd2: if (idle) opa <= merge(opa, EXT_HWDATA, be_ff);
                    4'd3: if (idle) opb <= merge(opb, EXT_HWDATA, be_ff);
                    4'd4: if (idle) res_lo <= merge(res_lo, EXT_HWDATA, be_ff);
                    4'd5: if (idle) res_hi <= merge(res_hi, EXT_HWDATA, be_ff);
                    default: ;
                endcase
            end
            if (last) {res_hi, res_lo} <= final_res;
            // Completion outranks a simultaneous write-1-to-clear
            if (last)
                done <= 1'b1;
            else if (start)
                done <= 1'b0;
            else if (we && addr_ff == 4'd1 && be_ff[0] && EXT_HWDATA[1])
                done <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            prod    <= '0;
            mcand   <= '0;
            mplier  <= '0;
            run_acc <= 1'b0;
        end else if (start) begin
            state   <= RUN;
            cnt     <= '0;
            prod    <= '0;
            mcand   <= {32'd0, opa};
            mplier  <= opb;
            run_acc <= EXT_HWDATA[1];
        end else if (busy) begin
            prod   <= next_prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last) state <= IDLE;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr_ff)
            4'd0: rdata = {30'd0, acc, 1'b0};
            4'd1: rdata = {30'd0, done, busy};
            4'd2: rdata = opa;
            4'd3: rdata = opb;
            4'd4: rdata = res_lo;
            4'd5: rdata = res_hi;
            default: rdata = 32'd0;
        endcase
    end

    assign EXT_HRDATA = (dv && !wr_ff && !stall && be_ff != 4'b0000)
                        ? rdata : 32'd0;

endmodule

// File: tb/tb_ext_acc_slave.sv
// Scoreboard bench for ext_acc_slave: reads push expected data,
// a negedge monitor pops and compares on each completed read.
module tb_ext_acc_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EXT_HSEL;
    logic [15:0] EXT_HADDR;
    logic        EXT_HWRITE;
    logic [3:0]  EXT_HSIZE;
    logic [31:0] EXT_HWDATA;
    logic [31:0] EXT_HRDATA;
    logic        EXT_HREADYOUT;
    logic        busy;

    int checks = 0;
    int failures = 0;
    logic rd_dp = 1'b0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    ext_acc_slave dut (
        .clk(clk), .rst_n(rst_n),
        .EXT_HSEL(EXT_HSEL), .EXT_HADDR(EXT_HADDR),
        .EXT_HWRITE(EXT_HWRITE), .EXT_HSIZE(EXT_HSIZE),
        .EXT_HWDATA(EXT_HWDATA), .EXT_HRDATA(EXT_HRDATA),
        .EXT_HREADYOUT(EXT_HREADYOUT), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_dp && EXT_HREADYOUT) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read got=%h required=none", EXT_HRDATA);
            end else begin
                logic [31:0] e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (EXT_HRDATA !== e) begin
                    failures++;
                    $display("FAIL %s got=%h required=%h", n, EXT_HRDATA, e);
                end
            end
        end
    end

    task automatic check(input string n, input logic [63:0] got,
                         input logic [63:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", n, got, req);
        end
    endtask

    task automatic xfer(input logic w, input logic [15:0] a,
                        input logic [3:0] sz, input logic [31:0] wd,
                        input logic [31:0] ex, input string n,
                        output int stalls);
        int k;
        EXT_HSEL = 1'b1; EXT_HWRITE = w; EXT_HADDR = a; EXT_HSIZE = sz;
        @(posedge clk); #1;
        EXT_HSEL = 1'b0; EXT_HWDATA = wd;
        if (!w) begin
            exp_q.push_back(ex);
            name_q.push_back(n);
            rd_dp = 1'b1;
        end
        k = 0;
        while (!EXT_HREADYOUT && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        stalls = k;
        if (k >= 100) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got=stalled required=ready", n);
            rd_dp = 1'b0;
            if (exp_q.size() > 0) begin
                void'(exp_q.pop_back());
                void'(name_q.pop_back());
            end
        end else begin
            @(posedge clk); #1;
            rd_dp = 1'b0;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [3:0] sz,
                      input logic [31:0] d);
        int s;
        xfer(1'b1, a, sz, d, 32'd0, "wr", s);
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] ex,
                      input string n);
        int s;
        xfer(1'b0, a, 4'b0010, 32'd0, ex, n, s);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout got=busy required=idle");
        end
    endtask

    initial begin
        int n, s;
        rst_n = 1'b0;
        EXT_HSEL = 1'b0; EXT_HADDR = '0; EXT_HWRITE = 1'b0;
        EXT_HSIZE = 4'b0010; EXT_HWDATA = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(EXT_HREADYOUT), 64'd1);
        check("rst_rdata", 64'(EXT_HRDATA), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_rdata", 64'(EXT_HRDATA), 64'd0);
        rd(16'h0004, 32'd0, "status_rst");
        rd(16'h0008, 32'd0, "opa_rst");
        rd(16'h0010, 32'd0, "reslo_rst");

        // basic multiply
        wr(16'h0008, 4'b0010, 32'h0000FFFF);
        wr(16'h000C, 4'b0010, 32'h00010000);
        wr(16'h0000, 4'b0010, 32'h00000001);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check("busy_cycles", 64'(n), 64'd32);
        rd(16'h0004, 32'h2, "status_done");
        rd(16'h0010, 32'hFFFF0000, "mul_lo");
        rd(16'h0014, 32'h0, "mul_hi");

        // stalled result read
        wr(16'h0000, 4'b0010, 32'h00000001);
        repeat (2) @(posedge clk);
        #1;
        xfer(1'b0, 16'h0010, 4'b0010, 32'd0, 32'hFFFF0000, "stall_lo", s);
        check("stall_cycles", 64'(s), 64'd29);

        // byte lanes
        wr(16'h0008, 4'b0010, 32'h0);
        wr(16'h0009, 4'b0000, 32'hABABABAB);
        rd(16'h0008, 32'h0000AB00, "sb_opa");
        wr(16'h0009, 4'b0001, 32'h12341234);
        rd(16'h0008, 32'h0000AB00, "sh_misal");
        wr(16'h000A, 4'b0001, 32'h12341234);
        rd(16'h0008, 32'h1234AB00, "sh_opa");
        rd(16'h0048, 32'h1234AB00, "alias_opa");
        xfer(1'b0, 16'h0008, 4'b0011, 32'd0, 32'd0, "bad_size", s);
        rd(16'h0018, 32'd0, "unmapped");

        // accumulate with wrap
        wr(16'h0008, 4'b0010, 32'hFFFFFFFF);
        wr(16'h000C, 4'b0010, 32'hFFFFFFFF);
        wr(16'h0010, 4'b0010, 32'h0);
        wr(16'h0014, 4'b0010, 32'h0);
        wr(16'h0000, 4'b0010, 32'h00000003);
        wr(16'h0008, 4'b0010, 32'h00000005);
        wait_idle(n);
        rd(16'h0008, 32'hFFFFFFFF, "opa_locked");
        rd(16'h0010, 32'h00000001, "acc1_lo");
        rd(16'h0014, 32'hFFFFFFFE, "acc1_hi");
        wr(16'h0000, 4'b0010, 32'h00000003);
        wait_idle(n);
        rd(16'h0010, 32'h00000002, "acc2_lo");
        rd(16'h0014, 32'hFFFFFFFC, "acc2_hi");
        rd(16'h0000, 32'h00000002, "ctrl_rd");
        wr(16'h0004, 4'b0010, 32'h00000002);
        rd(16'h0004, 32'h0, "done_w1c");

        // reset in the middle of a run
        wr(16'h0008, 4'b0010, 32'h3);
        wr(16'h000C, 4'b0010, 32'h5);
        wr(16'h0000, 4'b0010, 32'h1);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", 64'(busy), 64'd0);
        check("async_ready", 64'(EXT_HREADYOUT), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        rd(16'h0010, 32'd0, "rst_reslo");
        rd(16'h0004, 32'd0, "rst_status");
        wr(16'h0008, 4'b0010, 32'h00000077);
        rd(16'h0008, 32'h00000077, "post_rst_opa");

        repeat (2) @(posedge clk);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
